ps2_host_tx: RTL

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_host_tx.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter.
// The host holds the clock line low (inhibit), pulls data low for the start bit,
// and releases the clock. It then shifts out eight data bits LSB first, odd parity
// and a stop bit, one bit per device falling edge. It then waits for the device
// ack and for both lines to return idle-high.
// Optional feature macro: PS2_TX_RETRY_EN. When it is defined, one failed frame
// (timeout or missing ack) is retried from the inhibit phase with the same byte
// before error is reported.
module ps2_host_tx #(
  parameter int CLK_KHZ    = 6500,
  parameter int INHIBIT_US = 120,
  parameter int TIMEOUT_MS = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2clk_in,
  input  logic       ps2data_in,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       ps2clk_oe,
  output logic       ps2data_oe,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int INHIBIT_CYCLES = CLK_KHZ * INHIBIT_US / 1000;
  localparam int TIMEOUT_CYCLES = CLK_KHZ * TIMEOUT_MS;
  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, START, SHIFT, ACK, WAIT_IDLE
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       clk_sync_q, clk_sync_d;
  logic [1:0]       data_sync_q, data_sync_d;
  logic             clk_prev_q, clk_prev_d;
  logic [9:0]       frame_q, frame_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
`ifdef PS2_TX_RETRY_EN
  logic             retry_q, retry_d;
`endif

  logic clk_s, data_s, fall, fail;

  assign clk_s  = clk_sync_q[1];
  assign data_s = data_sync_q[1];
  assign fall   = clk_prev_q & ~clk_s;

  assign ps2clk_oe  = clk_oe_q;
  assign ps2data_oe = data_oe_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

  // Next-state and next-output logic for the whole frame sequence; any failure
  // (timeout or missing ack) overrides whatever the state decided this cycle.
  always_comb begin
    clk_sync_d  = {clk_sync_q[0], ps2clk_in};
    data_sync_d = {data_sync_q[0], ps2data_in};
    clk_prev_d  = clk_s;
    state_d     = state_q;
    frame_d     = frame_q;
    bit_cnt_d   = bit_cnt_q;
    inh_cnt_d   = inh_cnt_q;
    to_cnt_d    = to_cnt_q;
    clk_oe_d    = clk_oe_q;
    data_oe_d   = data_oe_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    error_d     = 1'b0;
    fail        = 1'b0;
`ifdef PS2_TX_RETRY_EN
    retry_d     = retry_q;
`endif

    case (state_q)
      IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        busy_d    = 1'b0;
        inh_cnt_d = '0;
        to_cnt_d  = '0;
`ifdef PS2_TX_RETRY_EN
        retry_d   = 1'b0;
`endif
        if (tx_start) begin
          frame_d  = {1'b1, ~^tx_data, tx_data};
          busy_d   = 1'b1;
          clk_oe_d = 1'b1;
          state_d  = INHIBIT;
        end
      end
      INHIBIT: begin
        to_cnt_d = '0;
        if (inh_cnt_q == INH_LAST) begin
          inh_cnt_d = '0;
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
          state_d   = START;
        end else begin
          inh_cnt_d = inh_cnt_q + 1'b1;
        end
      end
      START: begin
        bit_cnt_d = '0;
        state_d   = SHIFT;
      end
      SHIFT: begin
        if (fall) begin
          data_oe_d = ~frame_q[bit_cnt_q];
          if (bit_cnt_q == 4'd9) begin
            state_d = ACK;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      ACK: begin
        if (fall) begin
          if (!data_s) begin
            state_d = WAIT_IDLE;
          end else begin
            fail = 1'b1;
          end
        end
      end
      WAIT_IDLE: begin
        if (clk_s && data_s) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_q == START || state_q == SHIFT || state_q == ACK || state_q == WAIT_IDLE) begin
      to_cnt_d = to_cnt_q + 1'b1;
      if (to_cnt_q == TO_LAST) begin
        fail = 1'b1;
      end
    end

    if (fail) begin
      done_d    = 1'b0;
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      busy_d    = 1'b0;
      error_d   = 1'b1;
      to_cnt_d  = '0;
      state_d   = IDLE;
`ifdef PS2_TX_RETRY_EN
      if (!retry_q) begin
        retry_d   = 1'b1;
        clk_oe_d  = 1'b1;
        busy_d    = 1'b1;
        error_d   = 1'b0;
        inh_cnt_d = '0;
        state_d   = INHIBIT;
      end
`endif
    end
  end

  // State, counters, synchronizers and registered outputs; reset returns the
  // lines to released and the synchronizers to the idle-high level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
      frame_q     <= '0;
      bit_cnt_q   <= '0;
      inh_cnt_q   <= '0;
      to_cnt_q    <= '0;
      clk_oe_q    <= 1'b0;
      data_oe_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_prev_q  <= clk_prev_d;
      frame_q     <= frame_d;
      bit_cnt_q   <= bit_cnt_d;
      inh_cnt_q   <= inh_cnt_d;
      to_cnt_q    <= to_cnt_d;
      clk_oe_q    <= clk_oe_d;
      data_oe_q   <= data_oe_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
`ifdef PS2_TX_RETRY_EN
      retry_q     <= retry_d;
`endif
    end
  end

endmodule
